// File: rtl/l2_arbiter.sv
// Two-client arbiter between the I-cache and D-cache miss ports and a shared L2 cache.
// Ties are broken by alternating grants. The request to L2 is registered and stays frozen while a client is served.

package rv32i_types;

  typedef struct packed {
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata;
  } l2_go_t;

  typedef struct packed {
    logic         mem_resp;
    logic [255:0] mem_rdata;
  } l2_ret_t;

endpackage

module l2_arbiter
  import rv32i_types::*;
(
  input  logic    clk,
  input  logic    rst,
  input  l2_go_t  i_go,
  output l2_ret_t i_ret,
  input  l2_go_t  d_go,
  output l2_ret_t d_ret,
  output l2_go_t  l2_go,
  input  l2_ret_t l2_ret
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state;
  state_t next_state;
  logic   last_grant_d;
  logic   grant_i;
  logic   grant_d;
  logic   i_pending;
  logic   d_pending;

  assign i_pending = i_go.mem_read | i_go.mem_write;
  assign d_pending = d_go.mem_read | d_go.mem_write;

  always_comb begin
    next_state = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (i_pending && d_pending) begin
          grant_i = last_grant_d;
          grant_d = ~last_grant_d;
        end else begin
          grant_i = i_pending;
          grant_d = d_pending;
        end
        if (grant_i)      next_state = SERVE_I;
        else if (grant_d) next_state = SERVE_D;
      end
      SERVE_I, SERVE_D: begin
        if (l2_ret.mem_resp) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      l2_go        <= '0;
      last_grant_d <= 1'b0;
    end else begin
      state <= next_state;
      if (grant_i) begin
        l2_go        <= i_go;
        last_grant_d <= 1'b0;
      end else if (grant_d) begin
        l2_go        <= d_go;
        last_grant_d <= 1'b1;
      end else if (state != IDLE && l2_ret.mem_resp) begin
        l2_go.mem_read  <= 1'b0;
        l2_go.mem_write <= 1'b0;
      end
    end
  end

  // Response data fans out to both clients; only the strobe is steered, and it is held low while in reset.
  always_comb begin
    i_ret.mem_rdata = l2_ret.mem_rdata;
    d_ret.mem_rdata = l2_ret.mem_rdata;
    i_ret.mem_resp  = l2_ret.mem_resp && (state == SERVE_I) && !rst;
    d_ret.mem_resp  = l2_ret.mem_resp && (state == SERVE_D) && !rst;
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter.
// A per-cycle vector table is followed by hand-written sequences for writeback and combined read/write requests.

module tb_l2_arbiter;
  import rv32i_types::*;

  logic    clk;
  logic    rst;
  l2_go_t  i_go;
  l2_go_t  d_go;
  l2_ret_t i_ret;
  l2_ret_t d_ret;
  l2_go_t  l2_go;
  l2_ret_t l2_ret;

  int testsRun;
  int testsFailed;

  localparam logic [255:0] I_WDATA = {8{32'h0BAD_F00D}};
  localparam logic [255:0] D_WDATA = {8{32'h1234_5678}};

  typedef struct {
    logic        rstIn;
    logic        iRd;
    logic        iWr;
    logic [31:0] iAddr;
    logic        dRd;
    logic        dWr;
    logic [31:0] dAddr;
    logic        resp;
    logic        expIResp;
    logic        expDResp;
    logic        expRd;
    logic        expWr;
    logic [31:0] expAddr;
  } vec_t;

  vec_t vecs[$];

  l2_arbiter dut (
    .clk    (clk),
    .rst    (rst),
    .i_go   (i_go),
    .i_ret  (i_ret),
    .d_go   (d_go),
    .d_ret  (d_ret),
    .l2_go  (l2_go),
    .l2_ret (l2_ret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against the bench's expected value and tallies the result.
  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic addVec(input logic r, input logic ir, input logic iw, input logic [31:0] ia,
                        input logic dr, input logic dw, input logic [31:0] da, input logic rs,
                        input logic ei, input logic ed, input logic erd, input logic ewr,
                        input logic [31:0] ea);
    vec_t v;
    v.rstIn = r;  v.iRd = ir; v.iWr = iw; v.iAddr = ia;
    v.dRd = dr;   v.dWr = dw; v.dAddr = da; v.resp = rs;
    v.expIResp = ei; v.expDResp = ed; v.expRd = erd; v.expWr = ewr; v.expAddr = ea;
    vecs.push_back(v);
  endtask

  // Drives one cycle of inputs at the falling edge, checks same-cycle responses, then the registered request after the rising edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    logic [255:0] rdata;
    rdata = {8{32'hAAAA_AAAA}} ^ 256'(idx);
    rst = v.rstIn;
    i_go = '{mem_read: v.iRd, mem_write: v.iWr, mem_address: v.iAddr, mem_wdata: I_WDATA};
    d_go = '{mem_read: v.dRd, mem_write: v.dWr, mem_address: v.dAddr, mem_wdata: D_WDATA};
    l2_ret = '{mem_resp: v.resp, mem_rdata: rdata};
    #1;
    checkOutput($sformatf("row%0d i_resp", idx), 256'(i_ret.mem_resp), 256'(v.expIResp));
    checkOutput($sformatf("row%0d d_resp", idx), 256'(d_ret.mem_resp), 256'(v.expDResp));
    checkOutput($sformatf("row%0d i_rdata", idx), i_ret.mem_rdata, rdata);
    checkOutput($sformatf("row%0d d_rdata", idx), d_ret.mem_rdata, rdata);
    @(posedge clk);
    #1;
    checkOutput($sformatf("row%0d l2_rd", idx), 256'(l2_go.mem_read), 256'(v.expRd));
    checkOutput($sformatf("row%0d l2_wr", idx), 256'(l2_go.mem_write), 256'(v.expWr));
    checkOutput($sformatf("row%0d l2_addr", idx), 256'(l2_go.mem_address), 256'(v.expAddr));
    @(negedge clk);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst    = 1'b1;
    i_go   = '0;
    d_go   = '0;
    l2_ret = '0;

    //     rst ir iw iaddr         dr dw daddr         rsp  eI eD rd wr addr
    addVec(1, 0, 0, 32'h0,        0, 0, 32'h0,        1,   0, 0, 0, 0, 32'h0);
    addVec(0, 0, 0, 32'h0,        1, 0, 32'h0000_1000, 0,  0, 0, 1, 0, 32'h1000);
    addVec(0, 0, 0, 32'h0,        1, 0, 32'h0000_1000, 0,  0, 0, 1, 0, 32'h1000);
    addVec(0, 0, 0, 32'h0,        1, 0, 32'h0000_1000, 0,  0, 0, 1, 0, 32'h1000);
    addVec(0, 0, 0, 32'h0,        1, 0, 32'h0000_1000, 1,  0, 1, 0, 0, 32'h1000);
    addVec(0, 0, 0, 32'h0,        0, 0, 32'h0,        1,   0, 0, 0, 0, 32'h1000);
    addVec(1, 0, 0, 32'h0,        0, 0, 32'h0,        0,   0, 0, 0, 0, 32'h0);
    addVec(0, 1, 0, 32'h3000,     1, 0, 32'h4000,     0,   0, 0, 1, 0, 32'h4000);
    addVec(0, 1, 0, 32'h3000,     1, 0, 32'h4000,     1,   0, 1, 0, 0, 32'h4000);
    addVec(0, 1, 0, 32'h3000,     1, 0, 32'h4000,     0,   0, 0, 1, 0, 32'h3000);
    addVec(0, 1, 0, 32'h3000,     1, 0, 32'h4000,     1,   1, 0, 0, 0, 32'h3000);
    addVec(0, 1, 0, 32'h3000,     1, 0, 32'h4000,     0,   0, 0, 1, 0, 32'h4000);
    addVec(0, 1, 0, 32'h5000,     1, 0, 32'h4000,     0,   0, 0, 1, 0, 32'h4000);
    addVec(0, 1, 0, 32'h5000,     1, 0, 32'h4000,     1,   0, 1, 0, 0, 32'h4000);
    addVec(0, 1, 0, 32'h5000,     1, 0, 32'h4000,     0,   0, 0, 1, 0, 32'h5000);
    addVec(0, 1, 0, 32'h5000,     1, 0, 32'h6000,     0,   0, 0, 1, 0, 32'h5000);
    addVec(0, 1, 0, 32'h5000,     1, 0, 32'h7000,     0,   0, 0, 1, 0, 32'h5000);
    addVec(0, 1, 0, 32'h5000,     1, 0, 32'h7000,     1,   1, 0, 0, 0, 32'h5000);
    addVec(0, 1, 0, 32'h5000,     1, 0, 32'h7000,     0,   0, 0, 1, 0, 32'h7000);
    addVec(0, 0, 0, 32'h0,        1, 0, 32'h7000,     1,   0, 1, 0, 0, 32'h7000);
    addVec(0, 0, 0, 32'h0,        1, 0, 32'h8000,     0,   0, 0, 1, 0, 32'h8000);
    addVec(0, 0, 0, 32'h0,        1, 0, 32'h8000,     0,   0, 0, 1, 0, 32'h8000);
    addVec(1, 0, 0, 32'h0,        0, 0, 32'h0,        1,   0, 0, 0, 0, 32'h0);
    addVec(0, 0, 0, 32'h0,        0, 0, 32'h0,        0,   0, 0, 0, 0, 32'h0);
    addVec(0, 0, 0, 32'h0,        0, 0, 32'h0,        1,   0, 0, 0, 0, 32'h0);
    addVec(0, 1, 0, 32'h9000,     0, 0, 32'h0,        0,   0, 0, 1, 0, 32'h9000);
    addVec(0, 0, 0, 32'h0,        0, 0, 32'h0,        0,   0, 0, 1, 0, 32'h9000);
    addVec(0, 0, 0, 32'h0,        0, 0, 32'h0,        1,   1, 0, 0, 0, 32'h9000);

    @(negedge clk);
    foreach (vecs[k]) applyStimulus(vecs[k], k);

    // Writeback from D: request and data must appear verbatim one edge later.
    d_go = '{mem_read: 1'b0, mem_write: 1'b1, mem_address: 32'h2000, mem_wdata: D_WDATA};
    i_go = '0;
    l2_ret = '0;
    @(posedge clk); #1;
    checkOutput("wb l2_wr", 256'(l2_go.mem_write), 256'(1'b1));
    checkOutput("wb l2_rd", 256'(l2_go.mem_read), 256'(1'b0));
    checkOutput("wb l2_addr", 256'(l2_go.mem_address), 256'(32'h2000));
    checkOutput("wb l2_wdata", l2_go.mem_wdata, D_WDATA);
    @(negedge clk);
    l2_ret = '{mem_resp: 1'b1, mem_rdata: {8{32'hCAFE_0001}}};
    #1;
    checkOutput("wb d_resp", 256'(d_ret.mem_resp), 256'(1'b1));
    checkOutput("wb i_resp", 256'(i_ret.mem_resp), 256'(1'b0));
    checkOutput("wb i_rdata", i_ret.mem_rdata, {8{32'hCAFE_0001}});
    d_go = '0;
    @(posedge clk); #1;
    checkOutput("wb l2_wr clear", 256'(l2_go.mem_write), 256'(1'b0));
    @(negedge clk);
    l2_ret = '0;

    // Read and write both set from I: passed through untouched.
    i_go = '{mem_read: 1'b1, mem_write: 1'b1, mem_address: 32'hA000, mem_wdata: I_WDATA};
    @(posedge clk); #1;
    checkOutput("rw l2_rd", 256'(l2_go.mem_read), 256'(1'b1));
    checkOutput("rw l2_wr", 256'(l2_go.mem_write), 256'(1'b1));
    checkOutput("rw l2_wdata", l2_go.mem_wdata, I_WDATA);
    @(negedge clk);
    l2_ret = '{mem_resp: 1'b1, mem_rdata: '0};
    #1;
    checkOutput("rw i_resp", 256'(i_ret.mem_resp), 256'(1'b1));
    checkOutput("rw d_resp", 256'(d_ret.mem_resp), 256'(1'b0));
    i_go = '0;
    @(posedge clk); #1;
    checkOutput("rw clear", 256'({l2_go.mem_read, l2_go.mem_write}), 256'(2'b00));
    @(negedge clk);
    l2_ret = '0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
